// File: rtl/traffic_light_decoder.sv
// Lamp-line observer: decodes green/yellow/red back into the 2-bit traffic
// light state code, checks phase order and minimum dwell, and measures phases.
module traffic_light_decoder #(
  parameter int DWELL_W   = 16,
  parameter int MIN_DWELL = 2,
  parameter int ERR_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [0:2]         ld,
  output logic [1:0]         state,
  output logic               state_valid,
  output logic               changed,
  output logic               seq_err,
  output logic               illegal_err,
  output logic               short_err,
  output logic [DWELL_W-1:0] dwell,
  output logic [DWELL_W-1:0] last_dwell,
  output logic [ERR_W-1:0]   err_cnt
);

  // Low two bits of each synced state equal its external state code.
  typedef enum logic [2:0] {
    GREEN   = 3'b000,
    YELLOW1 = 3'b001,
    RED     = 3'b010,
    YELLOW2 = 3'b011,
    UNSYNC  = 3'b100
  } trk_t;

  localparam logic [DWELL_W:0] MIN_DWELL_W = (DWELL_W+1)'(MIN_DWELL);

  function automatic trk_t legal_next(input trk_t s);
    case (s)
      GREEN:   legal_next = YELLOW1;
      YELLOW1: legal_next = RED;
      RED:     legal_next = YELLOW2;
      YELLOW2: legal_next = GREEN;
      default: legal_next = UNSYNC;
    endcase
  endfunction

  logic [0:2]         ld_q_r;
  trk_t               trk_r;
  trk_t               trk_nxt_s;
  trk_t               implied_s;
  logic               pat_ok_s;
  logic               chg_s;
  logic               seq_s;
  logic               ill_s;
  logic               shrt_s;
  logic [1:0]         state_nxt_s;
  logic               valid_nxt_s;
  logic [DWELL_W:0]   dwell_inc_s;
  logic [DWELL_W-1:0] dwell_sat_s;
  logic [DWELL_W-1:0] dwell_nxt_s;
  logic [DWELL_W-1:0] last_nxt_s;
  logic [ERR_W-1:0]   err_nxt_s;

  // Classify the sampled lamp pattern into the state it implies from here.
  always_comb begin
    pat_ok_s  = 1'b1;
    implied_s = trk_r;
    case (ld_q_r)
      3'b100: implied_s = GREEN;
      3'b001: implied_s = RED;
      3'b010: begin
        // Yellow is resolved by history; already in a yellow phase means stay.
        case (trk_r)
          GREEN:   implied_s = YELLOW1;
          RED:     implied_s = YELLOW2;
          YELLOW1: implied_s = YELLOW1;
          YELLOW2: implied_s = YELLOW2;
          default: implied_s = UNSYNC;
        endcase
      end
      default: begin
        pat_ok_s  = 1'b0;
        implied_s = UNSYNC;
      end
    endcase
  end

  // Tracker next-state, pulse and dwell computation.
  always_comb begin
    trk_nxt_s   = trk_r;
    chg_s       = 1'b0;
    seq_s       = 1'b0;
    ill_s       = 1'b0;
    shrt_s      = 1'b0;
    state_nxt_s = state;
    valid_nxt_s = state_valid;
    last_nxt_s  = last_dwell;
    dwell_inc_s = {1'b0, dwell} + {{DWELL_W{1'b0}}, 1'b1};
    dwell_sat_s = dwell_inc_s[DWELL_W] ? {DWELL_W{1'b1}} : dwell_inc_s[DWELL_W-1:0];
    dwell_nxt_s = dwell;
    if (trk_r == UNSYNC) begin
      dwell_nxt_s = {DWELL_W{1'b0}};
      if (implied_s != UNSYNC) begin
        trk_nxt_s   = implied_s;
        chg_s       = 1'b1;
        state_nxt_s = implied_s[1:0];
        valid_nxt_s = 1'b1;
      end else begin
        trk_nxt_s   = UNSYNC;
      end
    end else if (!pat_ok_s) begin
      trk_nxt_s   = UNSYNC;
      ill_s       = 1'b1;
      valid_nxt_s = 1'b0;
      dwell_nxt_s = {DWELL_W{1'b0}};
    end else if (implied_s == trk_r) begin
      dwell_nxt_s = dwell_sat_s;
    end else begin
      trk_nxt_s   = implied_s;
      chg_s       = 1'b1;
      seq_s       = (implied_s != legal_next(trk_r));
      shrt_s      = (dwell_inc_s < MIN_DWELL_W);
      state_nxt_s = implied_s[1:0];
      dwell_nxt_s = {DWELL_W{1'b0}};
      last_nxt_s  = dwell_sat_s;
    end
    if ((seq_s || ill_s) && (err_cnt != {ERR_W{1'b1}})) begin
      err_nxt_s = err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_nxt_s = err_cnt;
    end
  end

  // Input sampling, tracker state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q_r      <= 3'b000;
      trk_r       <= UNSYNC;
      state       <= 2'b00;
      state_valid <= 1'b0;
      changed     <= 1'b0;
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      short_err   <= 1'b0;
      dwell       <= {DWELL_W{1'b0}};
      last_dwell  <= {DWELL_W{1'b0}};
      err_cnt     <= {ERR_W{1'b0}};
    end else begin
      ld_q_r      <= ld;
      trk_r       <= trk_nxt_s;
      state       <= state_nxt_s;
      state_valid <= valid_nxt_s;
      changed     <= chg_s;
      seq_err     <= seq_s;
      illegal_err <= ill_s;
      short_err   <= shrt_s;
      dwell       <= dwell_nxt_s;
      last_dwell  <= last_nxt_s;
      err_cnt     <= err_nxt_s;
    end
  end

endmodule
